// File: rtl/waveform_analyzer.sv
// Hysteretic threshold-crossing analyzer: measures period, minimum and maximum
// of each waveform cycle between consecutive rising crossings.
module waveform_analyzer #(
   parameter int DATA_W   = 12,
   parameter int PERIOD_W = 24,
   parameter int HYST     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   sample,
   input  logic                sample_valid,
   input  logic [DATA_W-1:0]   threshold,
   input  logic                clear,
   output logic [PERIOD_W-1:0] period_out,
   output logic [DATA_W-1:0]   min_out,
   output logic [DATA_W-1:0]   max_out,
   output logic                result_valid,
   output logic                overflow
);

   typedef enum logic [1:0] {SEEK_LOW, SEEK_RISE, MEAS_HIGH, MEAS_LOW} state_t;

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]   min_q, min_d, max_q, max_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [DATA_W-1:0]   min_out_q, min_out_d, max_out_q, max_out_d;
   logic                rv_q, rv_d, ovf_q, ovf_d;

   logic [DATA_W:0]     thr_sum_s;
   logic [DATA_W-1:0]   thr_hi_s, thr_lo_s;
   logic                is_lo_s, is_hi_s, cnt_max_s;

   // Saturating hysteresis band around the threshold, plus crossing qualifiers
   always_comb begin
      thr_sum_s = {1'b0, threshold} + (DATA_W+1)'(HYST);
      if (thr_sum_s[DATA_W]) begin
         thr_hi_s = {DATA_W{1'b1}};
      end else begin
         thr_hi_s = thr_sum_s[DATA_W-1:0];
      end
      if (threshold >= DATA_W'(HYST)) begin
         thr_lo_s = threshold - DATA_W'(HYST);
      end else begin
         thr_lo_s = '0;
      end
      is_lo_s   = sample_valid && (sample <= thr_lo_s);
      is_hi_s   = sample_valid && (sample >= thr_hi_s);
      cnt_max_s = (cnt_q == {PERIOD_W{1'b1}});
   end

   // Next-state, tracker and publish logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      min_d     = min_q;
      max_d     = max_q;
      period_d  = period_q;
      min_out_d = min_out_q;
      max_out_d = max_out_q;
      rv_d      = 1'b0;
      ovf_d     = 1'b0;
      if (clear) begin
         state_d = SEEK_LOW;
         cnt_d   = '0;
         min_d   = '0;
         max_d   = '0;
      end else begin
         case (state_q)
            SEEK_LOW: begin
               if (is_lo_s) state_d = SEEK_RISE;
               else         state_d = SEEK_LOW;
            end
            SEEK_RISE: begin
               if (is_hi_s) begin
                  state_d = MEAS_HIGH;
                  cnt_d   = PERIOD_W'(1);
                  min_d   = sample;
                  max_d   = sample;
               end else begin
                  state_d = SEEK_RISE;
               end
            end
            MEAS_HIGH, MEAS_LOW: begin
               // A closing crossing beats a simultaneous saturation
               if (state_q == MEAS_LOW && is_hi_s) begin
                  period_d  = cnt_q;
                  min_out_d = min_q;
                  max_out_d = max_q;
                  rv_d      = 1'b1;
                  cnt_d     = PERIOD_W'(1);
                  min_d     = sample;
                  max_d     = sample;
                  state_d   = MEAS_HIGH;
               end else if (cnt_max_s) begin
                  ovf_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = SEEK_LOW;
               end else begin
                  cnt_d = cnt_q + PERIOD_W'(1);
                  if (sample_valid && sample < min_q) min_d = sample;
                  else                                min_d = min_q;
                  if (sample_valid && sample > max_q) max_d = sample;
                  else                                max_d = max_q;
                  if (state_q == MEAS_HIGH && is_lo_s) state_d = MEAS_LOW;
                  else                                 state_d = state_q;
               end
            end
            default: begin
               state_d = SEEK_LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEEK_LOW;
         cnt_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         period_q  <= '0;
         min_out_q <= '0;
         max_out_q <= '0;
         rv_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         min_q     <= min_d;
         max_q     <= max_d;
         period_q  <= period_d;
         min_out_q <= min_out_d;
         max_out_q <= max_out_d;
         rv_q      <= rv_d;
         ovf_q     <= ovf_d;
      end
   end

   assign period_out   = period_q;
   assign min_out      = min_out_q;
   assign max_out      = max_out_q;
   assign result_valid = rv_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench for waveform_analyzer: default build plus a PERIOD_W=8 build
// for the saturation scenario.
module tb_waveform_analyzer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] threshold = 12'd2048;
   logic [11:0] sample = 12'd0;
   logic        sample_valid = 1'b0;
   logic        clear = 1'b0;
   logic [11:0] s8 = 12'd0;
   logic        v8 = 1'b0;
   logic        clear8 = 1'b0;

   logic [23:0] period_out;
   logic [11:0] min_out, max_out;
   logic        result_valid, overflow;
   logic [7:0]  period8;
   logic [11:0] min8, max8;
   logic        rv8, ovf8;

   always #5 clk = ~clk;

   waveform_analyzer dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
      .threshold(threshold), .clear(clear), .period_out(period_out),
      .min_out(min_out), .max_out(max_out), .result_valid(result_valid),
      .overflow(overflow)
   );

   waveform_analyzer #(.PERIOD_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .sample(s8), .sample_valid(v8),
      .threshold(threshold), .clear(clear8), .period_out(period8),
      .min_out(min8), .max_out(max8), .result_valid(rv8),
      .overflow(ovf8)
   );

   typedef struct {
      int period;
      int mn;
      int mx;
   } exp_t;

   exp_t sb[$];
   exp_t sb8[$];
   exp_t e_m;
   exp_t e8_m;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_res = 0, n_res8 = 0, n_ovf = 0, n_ovf8 = 0;
   int res_cyc = 0, prev_res_cyc = 0, ovf8_cyc = 0;
   int pos = 0, ph = 0, gcnt = 0;
   bit sq = 1'b0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // kind: 0 sawtooth, 1 triangle, 2 square 2040/2056, 3 constant 4000
   task automatic run(input int tgt, input int kind, input int n, input int gate, input int step);
      int  smp;
      bit  vld;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         clear  = 1'b0;
         clear8 = 1'b0;
         smp    = 0;
         vld    = 1'b0;
         if (gcnt % gate == 0) begin
            vld = 1'b1;
            case (kind)
               0: begin smp = pos; pos = (pos + step) % 4096; end
               1: begin smp = (ph <= 4095) ? ph : 8190 - ph; ph = (ph + 1) % 8190; end
               2: begin smp = sq ? 2056 : 2040; sq = !sq; end
               default: smp = 4000;
            endcase
         end
         gcnt++;
         if (tgt == 0) begin
            sample = 12'(smp); sample_valid = vld; v8 = 1'b0;
         end else begin
            s8 = 12'(smp); v8 = vld; sample_valid = 1'b0;
         end
      end
   endtask

   task automatic do_clear(input int tgt);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      v8 = 1'b0;
      if (tgt == 0) clear = 1'b1;
      else          clear8 = 1'b1;
      pos = 0; ph = 0; gcnt = 0; sq = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitor: pops the scoreboard whenever a result is published
   initial forever begin
      @(negedge clk);
      if (result_valid) begin
         n_res++;
         prev_res_cyc = res_cyc;
         res_cyc = cyc;
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e_m = sb.pop_front();
            check("period", period_out, e_m.period);
            check("min", min_out, e_m.mn);
            check("max", max_out, e_m.mx);
         end
      end
      if (overflow) n_ovf++;
      if (rv8) begin
         n_res8++;
         if (sb8.size() == 0) begin
            check("unexpected_result8", 1, 0);
         end else begin
            e8_m = sb8.pop_front();
            check("period8", period8, e8_m.period);
            check("min8", min8, e8_m.mn);
            check("max8", max8, e8_m.mx);
         end
      end
      if (ovf8) begin
         n_ovf8++;
         ovf8_cyc = cyc;
      end
   end

   initial begin
      int n0, o0, cross_cyc;

      repeat (2) @(posedge clk);
      #1;
      check("rst_period", period_out, 0);
      check("rst_min", min_out, 0);
      check("rst_max", max_out, 0);
      check("rst_valid", result_valid, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;

      // Sawtooth: crossings every 4096 cycles
      do_clear(0);
      sb.push_back('{4096, 0, 4095});
      sb.push_back('{4096, 0, 4095});
      run(0, 0, 10300, 1, 1);
      check("saw_drained", sb.size(), 0);
      check("saw_count", n_res, 2);
      check("saw_spacing", res_cyc - prev_res_cyc, 4096);

      // Async reset mid-window
      run(0, 0, 1000, 1, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("arst_period", period_out, 0);
      check("arst_min", min_out, 0);
      check("arst_max", max_out, 0);
      #1;
      rst_n = 1'b1;

      // Clear mid-window: outputs hold, result only after two fresh crossings
      do_clear(0);
      sb.push_back('{4096, 0, 4095});
      run(0, 0, 6170, 1, 1);
      check("clr_first_drained", sb.size(), 0);
      run(0, 0, 3026, 1, 1);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      check("clr_hold_period", period_out, 4096);
      check("clr_hold_min", min_out, 0);
      check("clr_hold_max", max_out, 4095);
      check("clr_no_pulse", result_valid, 0);
      n0 = n_res;
      sb.push_back('{4096, 0, 4095});
      run(0, 0, 1100, 1, 1);
      check("clr_no_early_result", n_res, n0);
      run(0, 0, 4100, 1, 1);
      check("clr_result_count", n_res, n0 + 1);
      check("clr_drained", sb.size(), 0);

      // Triangle: period 8190
      do_clear(0);
      sb.push_back('{8190, 0, 4095});
      sb.push_back('{8190, 0, 4095});
      run(0, 1, 18460, 1, 1);
      check("tri_drained", sb.size(), 0);
      check("tri_spacing", res_cyc - prev_res_cyc, 8190);

      // Gated sawtooth: valid every 4th cycle
      do_clear(0);
      sb.push_back('{16384, 0, 4095});
      run(0, 0, 24700, 4, 1);
      check("gate_drained", sb.size(), 0);

      // Square wave inside the hysteresis band
      do_clear(0);
      n0 = n_res;
      o0 = n_ovf;
      run(0, 2, 400, 1, 1);
      check("hyst_no_result", n_res, n0);
      check("hyst_no_ovf", n_ovf, o0);

      // 8-bit counter build: one normal result first
      do_clear(1);
      sb8.push_back('{128, 0, 4064});
      run(1, 0, 200, 1, 32);
      check("ovf_pre_drained", sb8.size(), 0);
      n0 = n_res8;
      do_clear(1);
      run(1, 0, 1, 1, 32);
      run(1, 3, 1, 1, 1);
      cross_cyc = cyc + 1;
      run(1, 3, 300, 1, 1);
      check("ovf_count", n_ovf8, 1);
      check("ovf_latency", ovf8_cyc - cross_cyc, 255);
      check("ovf_no_result", n_res8, n0);
      @(negedge clk);
      check("ovf_hold_period", period8, 128);
      check("ovf_hold_min", min8, 0);
      check("ovf_hold_max", max8, 4064);

      // Resume sawtooth after overflow: results follow a full resync
      pos = 0;
      gcnt = 0;
      sb8.push_back('{128, 0, 4064});
      run(1, 0, 200, 1, 32);
      check("resume_drained", sb8.size(), 0);
      check("resume_count", n_res8, n0 + 1);

      check("main_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
